// File: rtl/sm83_irq_ctl.sv
// sm83 interrupt controller: edge-latches peripheral requests into IF, masks
// with IE, drives the core's irq vector and retires bits on one-hot iack.
// IF and IE are exposed as bus-mapped bytes with a registered read path.

// One IF bit with its own request edge detector.
module sm83_irq_bit (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic if_wr,
    input  logic wdata,
    input  logic iack,
    output logic if_bit
);
    logic req_q;

    // Bus write replaces the bit, iack clears it, a fresh edge sets it last
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q  <= 1'b0;
            if_bit <= 1'b0;
        end else begin
            req_q  <= req;
            if_bit <= ((if_wr ? wdata : if_bit) & ~iack) | (req & ~req_q);
        end
    end
endmodule

module sm83_irq_ctl #(
    parameter int          WORD_SIZE = 8,
    parameter int          NUM_IRQS  = 5,
    parameter logic [15:0] ADR_IF    = 16'hff0f,
    parameter logic [15:0] ADR_IE    = 16'hffff
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          adr,
    input  logic [WORD_SIZE-1:0] din,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 data_oe,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [NUM_IRQS-1:0]  req,
    output logic [WORD_SIZE-1:0] irq,
    input  logic [WORD_SIZE-1:0] iack
);
    logic [NUM_IRQS-1:0]  if_reg;
    logic [WORD_SIZE-1:0] ie_reg;
    logic                 wr_q;
    logic                 wr_edge;
    logic                 sel_if;
    logic                 sel_ie;
    logic                 unused_iack;

    // Acknowledge bits above the implemented lines have no target
    assign unused_iack = ^iack[WORD_SIZE-1:NUM_IRQS];

    assign sel_if  = (adr == ADR_IF);
    assign sel_ie  = (adr == ADR_IE);
    // Only the leading cycle of a write strobe commits
    assign wr_edge = wr & ~wr_q;

    genvar i;
    generate
        for (i = 0; i < NUM_IRQS; i++) begin : g_bit
            sm83_irq_bit u_bit (
                .clk    (clk),
                .reset  (reset),
                .req    (req[i]),
                .if_wr  (wr_edge & sel_if),
                .wdata  (din[i]),
                .iack   (iack[i]),
                .if_bit (if_reg[i])
            );
        end
    endgenerate

    // Write-strobe history and IE register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= 1'b0;
            ie_reg <= '0;
        end else begin
            wr_q <= wr;
            if (wr_edge && sel_ie)
                ie_reg <= din;
        end
    end

    // Registered read port; returns pre-update values, dout holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= '0;
            data_oe <= 1'b0;
        end else if (rd && sel_if) begin
            dout    <= {{(WORD_SIZE-NUM_IRQS){1'b1}}, if_reg};
            data_oe <= 1'b1;
        end else if (rd && sel_ie) begin
            dout    <= ie_reg;
            data_oe <= 1'b1;
        end else begin
            data_oe <= 1'b0;
        end
    end

    assign irq = {{(WORD_SIZE-NUM_IRQS){1'b0}}, if_reg & ie_reg[NUM_IRQS-1:0]};
endmodule
